// File: rtl/adder_bist_2b.sv
// Exhaustive self-test controller for an N-bit adder: sweeps every (a,b) pair,
// holds each for SETTLE cycles, checks s_in against a+b, counts errors and keeps the first failure.
module adder_bist_2b #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [N-1:0]   a_out,
  output logic [N-1:0]   b_out,
  input  logic [N:0]     s_in,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*N:0]   err_count,
  output logic [N-1:0]   fail_a,
  output logic [N-1:0]   fail_b,
  output logic           fail_valid
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_settle;
  logic [N:0]    w_ref;
  logic          w_mismatch;
  logic          w_last;

  assign w_ref      = {1'b0, a_out} + {1'b0, b_out};
  assign w_mismatch = (s_in != w_ref);
  assign w_last     = (&a_out) && (&b_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // start is only honoured from IDLE or DONE, so a pulse mid-run is ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = APPLY;
      APPLY:      if (r_settle == '0) w_state_nxt = CHECK;
      CHECK:      w_state_nxt = w_last ? DONE : APPLY;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == APPLY) || (r_state == CHECK);
    done = (r_state == DONE);
    pass = (r_state == DONE) && (err_count == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out      <= '0;
      b_out      <= '0;
      r_settle   <= '0;
      err_count  <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            a_out      <= '0;
            b_out      <= '0;
            r_settle   <= SETTLE_LD;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_valid <= 1'b0;
          end
        end
        APPLY: begin
          if (r_settle != '0) r_settle <= r_settle - 1'b1;
        end
        CHECK: begin
          if (w_mismatch) begin
            if (!(&err_count)) err_count <= err_count + 1'b1;
            if (!fail_valid) begin
              fail_a     <= a_out;
              fail_b     <= b_out;
              fail_valid <= 1'b1;
            end
          end
          // b is the low half of the combined counter, so it is the inner loop
          if (!w_last) begin
            {a_out, b_out} <= {a_out, b_out} + 1'b1;
            r_settle       <= SETTLE_LD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_2b.sv
// Bench for adder_bist_2b: a fault-injectable adder model feeds s_in, a scoreboard
// checks vector order, and a table of runs checks the end-of-run results.
module tb_adder_bist_2b;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   a_out, b_out;
  logic [N:0]     s_in;
  logic           busy, done, pass;
  logic [2*N:0]   err_count;
  logic [N-1:0]   fail_a, fail_b;
  logic           fail_valid;

  int total = 0;
  int bad   = 0;
  int fault = 0;

  logic [2*N-1:0] exp_vec[$];

  adder_bist_2b #(.N(N), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a_out), .b_out(b_out), .s_in(s_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b),
    .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;

  // adder under test: 0 correct, 1 sum bit0 stuck at 0, 2 sum bit2 stuck at 0
  logic [N:0] sum_ok;
  always_comb begin
    sum_ok = {1'b0, a_out} + {1'b0, b_out};
    case (fault)
      1:       s_in = sum_ok & 3'b110;
      2:       s_in = sum_ok & 3'b011;
      default: s_in = sum_ok;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard: each new vector seen while busy must be the next one queued
  logic           m_prev_busy = 1'b0;
  logic [N-1:0]   m_pa = '0, m_pb = '0;
  always @(negedge clk) begin
    logic [2*N:0] e;
    if (busy && (!m_prev_busy || a_out != m_pa || b_out != m_pb)) begin
      if (exp_vec.size() > 0) e = {1'b0, exp_vec.pop_front()};
      else                    e = '1;
      chk("vec_order", {27'd0, 1'b0, a_out, b_out}, {27'd0, e});
    end
    m_prev_busy = busy;
    m_pa        = a_out;
    m_pb        = b_out;
  end

  task automatic push_vectors();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        exp_vec.push_back(4'(a * 4 + b));
  endtask

  // called at a negedge; returns edges from the start edge to the done edge
  task automatic run(input int inject_at, output int cycles, output int busy_cycles);
    int k;
    push_vectors();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    busy_cycles = 0;
    forever begin
      @(negedge clk);
      if (k == 0) begin
        chk("start_clr_done", done, 0);
        chk("start_clr_err", err_count, 0);
        chk("start_clr_fv", fail_valid, 0);
      end
      if (done) break;
      if (busy) busy_cycles++;
      start = (k == inject_at);
      k++;
      if (k > 200) begin
        chk("done_timeout", k, 32);
        break;
      end
    end
    start = 1'b0;
    cycles = k;
  endtask

  typedef struct {
    int fault;
    int err;
    int fa;
    int fb;
    int fv;
    int pass;
  } run_t;

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    run_t tbl[5];
    int cyc, bcyc, k;

    tbl[0] = '{0, 0, 0, 0, 0, 1};
    tbl[1] = '{1, 8, 0, 1, 1, 0};
    tbl[2] = '{2, 6, 1, 3, 1, 0};
    tbl[3] = '{1, 8, 0, 1, 1, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 1};  // restart from done after a failing run

    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {busy, done, pass, fail_valid, a_out, b_out, fail_a, fail_b}, 0);
    chk("rst_err", err_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);

    for (int i = 0; i < 5; i++) begin
      fault = tbl[i].fault;
      run(-1, cyc, bcyc);
      chk("latency", cyc, 32);
      chk("busy_cycles", bcyc, 32);
      chk("queue_drained", exp_vec.size(), 0);
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      chk("pass", pass, tbl[i].pass);
      chk("err_count", err_count, tbl[i].err);
      chk("fail_a", fail_a, tbl[i].fa);
      chk("fail_b", fail_b, tbl[i].fb);
      chk("fail_valid", fail_valid, tbl[i].fv);
      chk("hold_last", {a_out, b_out}, 4'hF);
      repeat (2) @(negedge clk);
      chk("done_held", done, 1);
    end

    // start pulse in the middle of a run must be ignored
    fault = 0;
    run(10, cyc, bcyc);
    chk("inj_latency", cyc, 32);
    chk("inj_queue", exp_vec.size(), 0);
    chk("inj_pass", pass, 1);

    // reset during vector (2,1) of a failing run
    fault = 1;
    push_vectors();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(a_out == 2'd2 && b_out == 2'd1) && k < 100);
    chk("reach_2_1", {a_out, b_out}, 4'h9);
    chk("mid_err", err_count, 4);
    chk("mid_fv", fail_valid, 1);
    rst = 1'b1;
    #1;
    chk("abort_outs", {busy, done, pass, fail_valid, a_out, b_out, fail_a, fail_b}, 0);
    chk("abort_err", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_vec.delete();
    @(negedge clk);
    chk("abort_idle", {busy, done}, 0);
    fault = 0;
    run(-1, cyc, bcyc);
    chk("post_rst_latency", cyc, 32);
    chk("post_rst_queue", exp_vec.size(), 0);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_err", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
